// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: PC, memread/ready handshake, IF/ID register, skid buffer, redirect and squash.
// Optional performance counters (fetch_cnt, stall_cnt) are enabled by defining IFETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter int          ADDR_W   = 7
) (
    input  logic              clk,
    input  logic              res,
    output logic              memread,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              imem_ready,
    input  logic              id_stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    output logic              if_id_valid,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        boot_wait, boot_wait_next;
    logic [31:0] pc, pc_next;
    logic [31:0] req_pc, req_pc_next;
    logic        valid_next;
    logic [31:0] instr_next, ifpc_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [31:0] skid_pc, skid_pc_next;
    logic [31:0] target, seq_pc;
    logic        slot_free, load;

    assign imem_addr = req_pc[ADDR_W+1:2];

    always_comb begin
        state_next      = state;
        boot_wait_next  = boot_wait;
        pc_next         = pc;
        req_pc_next     = req_pc;
        valid_next      = if_id_valid;
        instr_next      = if_id_instr;
        ifpc_next       = if_id_pc;
        skid_instr_next = skid_instr;
        skid_pc_next    = skid_pc;
        load            = 1'b0;
        memread         = (state == FETCH) || (state == DRAIN);
        target          = branch_target & ~32'd3;
        seq_pc          = req_pc + 32'd4;
        slot_free       = !if_id_valid || !id_stall;

        if (if_id_valid && !id_stall)
            valid_next = 1'b0;

        // A redirect wins over everything; an unanswered request must be drained first.
        if (branch_taken) begin
            pc_next    = target;
            valid_next = 1'b0;
            if (memread && !imem_ready) begin
                state_next = DRAIN;
            end else begin
                state_next  = FETCH;
                req_pc_next = target;
            end
        end else begin
            case (state)
                BOOT: begin
                    if (boot_wait)
                        boot_wait_next = 1'b0;
                    else
                        state_next = FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        pc_next = seq_pc;
                        if (slot_free) begin
                            load        = 1'b1;
                            valid_next  = 1'b1;
                            instr_next  = imem_data;
                            ifpc_next   = req_pc;
                            req_pc_next = seq_pc;
                        end else begin
                            skid_instr_next = imem_data;
                            skid_pc_next    = req_pc;
                            state_next      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!id_stall) begin
                        load        = 1'b1;
                        valid_next  = 1'b1;
                        instr_next  = skid_instr;
                        ifpc_next   = skid_pc;
                        req_pc_next = pc;
                        state_next  = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        req_pc_next = pc;
                        state_next  = FETCH;
                    end
                end
                default: state_next = BOOT;
            endcase
        end
    end

    // boot_wait keeps memread low for one full cycle after reset release.
    always_ff @(posedge clk) begin
        if (!res) begin
            state       <= BOOT;
            boot_wait   <= 1'b1;
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
            if_id_pc    <= 32'd0;
            skid_instr  <= 32'd0;
            skid_pc     <= 32'd0;
        end else begin
            state       <= state_next;
            boot_wait   <= boot_wait_next;
            pc          <= pc_next;
            req_pc      <= req_pc_next;
            if_id_valid <= valid_next;
            if_id_instr <= instr_next;
            if_id_pc    <= ifpc_next;
            skid_instr  <= skid_instr_next;
            skid_pc     <= skid_pc_next;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!res) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (load)
                fetch_cnt <= fetch_cnt + 32'd1;
            if ((state == HOLD) || (if_id_valid && id_stall))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios followed by randomized traffic,
// with fetched instructions checked against a program-order reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0004;
    localparam int          ADDR_W   = 7;

    logic              clk;
    logic              res;
    logic              memread;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_ready;
    logic              id_stall;
    logic              branch_taken;
    logic [31:0]       branch_target;
    logic              if_id_valid;
    logic [31:0]       if_id_instr;
    logic [31:0]       if_id_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       stall_cnt;
`endif

    logic [31:0] mem [128];
    logic [63:0] exp_q [$];
    logic [31:0] model_pc;
    logic        drain_pending;
    int          checks;
    int          failures;
    int          delivered;
    int          delivered_since_reset;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .res           (res),
        .memread       (memread),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .imem_ready    (imem_ready),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = imem_ready ? mem[imem_addr] : 32'hDEAD_BEEF;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, advances the program-order model for the coming edge,
    // and returns just after that edge.
    task automatic applyStimulus(input logic r, input logic ready, input logic stall,
                                 input logic br, input logic [31:0] tgt);
        res           = r;
        imem_ready    = ready;
        id_stall      = stall;
        branch_taken  = br;
        branch_target = tgt;
        if (!r) begin
            exp_q.delete();
            model_pc              = RESET_PC;
            drain_pending         = 1'b0;
            delivered_since_reset = 0;
        end else if (br) begin
            exp_q.delete();
            drain_pending = memread && !ready;
            model_pc      = tgt & ~32'd3;
        end else if (memread && ready) begin
            if (drain_pending) begin
                drain_pending = 1'b0;
            end else begin
                checkOutput("fetch_addr", 32'(imem_addr), 32'(model_pc[8:2]));
                exp_q.push_back({model_pc, mem[model_pc[8:2]]});
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        #3;
    endtask

    // Monitor: a fresh IF/ID load is visible when valid is set after an edge at which
    // the register was either empty or being consumed.
    initial begin : monitor
        logic        last_valid;
        logic [63:0] e;
        last_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (if_id_valid === 1'b1 && (last_valid !== 1'b1 || id_stall === 1'b0)) begin
                delivered++;
                delivered_since_reset++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_load: got pc %h instr %h, want no load", if_id_pc, if_id_instr);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ifid_pc", if_id_pc, e[63:32]);
                    checkOutput("ifid_instr", if_id_instr, e[31:0]);
                end
            end
            last_valid = if_id_valid;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, want completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [ADDR_W-1:0] prev_addr;
        int                d0;
        checks = 0;
        failures = 0;
        delivered = 0;
        delivered_since_reset = 0;
        model_pc = RESET_PC;
        drain_pending = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);

        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rst_memread", 32'(memread), 0);
        checkOutput("rst_addr", 32'(imem_addr), 1);
        checkOutput("rst_valid", 32'(if_id_valid), 0);
        checkOutput("rst_instr", if_id_instr, 0);
        checkOutput("rst_pc", if_id_pc, 0);

        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("boot_memread_edge1", 32'(memread), 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("boot_memread_edge2", 32'(memread), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("seq_pc0", if_id_pc, 4);
        checkOutput("seq_instr0", if_id_instr, 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("seq_pc1", if_id_pc, 8);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 1, 0, 0);
            checkOutput("stall_hold_pc", if_id_pc, 8);
            checkOutput("stall_memread", 32'(memread), 0);
        end
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("skid_pc", if_id_pc, 12);
        checkOutput("skid_next_memread", 32'(memread), 1);
        checkOutput("skid_next_addr", 32'(imem_addr), 4);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("after_skid_pc", if_id_pc, 16);

        d0 = delivered;
        for (int k = 0; k < 9; k++) begin
            prev_addr = imem_addr;
            applyStimulus(1, (k % 3) == 2, 0, 0, 0);
            if ((k % 3) != 2) checkOutput("wait_addr_stable", 32'(imem_addr), 32'(prev_addr));
        end
        checkOutput("wait_load_count", 32'(delivered - d0), 3);

        applyStimulus(1, 0, 0, 1, 32'h40);
        checkOutput("drain_valid", 32'(if_id_valid), 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("drain_discard_valid", 32'(if_id_valid), 0);
        checkOutput("drain_next_addr", 32'(imem_addr), 16);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("target_pc", if_id_pc, 32'h40);

        applyStimulus(1, 1, 1, 1, 32'h23);
        checkOutput("simul_valid", 32'(if_id_valid), 0);
        checkOutput("simul_addr", 32'(imem_addr), 8);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("simul_pc", if_id_pc, 32'h20);

        applyStimulus(1, 1, 0, 1, 32'h1FC);
        checkOutput("wrap_addr127", 32'(imem_addr), 127);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("wrap_addr0", 32'(imem_addr), 0);
        checkOutput("wrap_pc", if_id_pc, 32'h1FC);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("wrap_pc_next", if_id_pc, 32'h200);

        applyStimulus(1, 0, 0, 1, 32'h80);
        checkOutput("drain_memread", 32'(memread), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("drain_rst_memread", 32'(memread), 0);
        checkOutput("drain_rst_addr", 32'(imem_addr), 1);
        checkOutput("drain_rst_valid", 32'(if_id_valid), 0);
        checkOutput("drain_rst_instr", if_id_instr, 0);
        checkOutput("drain_rst_pc", if_id_pc, 0);

        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus(($urandom % 200) != 0, ($urandom % 4) != 0, ($urandom % 4) == 0,
                          ($urandom % 16) == 0, $urandom);
        end
        for (int c = 0; c < 20; c++) applyStimulus(1, 1, 0, 0, 0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
`ifdef IFETCH_PERF_CNT_EN
        checkOutput("fetch_cnt", fetch_cnt, 32'(delivered_since_reset));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
